reg_ram_portb_scheduler: RTL and testbench
==========================================

// Module: reg_ram_portb_scheduler
// PURPOSE
//  Owns port B of the 2-port register RAM (ram_2p_2kB_32b) in reg_interface. Avalon writes arrive on port A.
//  Periodically scans a block of N_CFG config words from RAM into atomically-updated shadow outputs (e.g. dds0_freq).
//  Arbitrates port B between that scanner and N_STS internal status writers (round-robin among writers).
//  Only one RAM operation is outstanding at any time.
// PARAMETERS
//  AW        11    RAM word-address width
//  DW        32    RAM data width
//  N_CFG     4     config words scanned per pass (>=1)
//  CFG_BASE  0     word address of first config word
//  N_STS     2     number of status write requesters (>=1)
//  RD_LAT    2     RAM read latency in clk cycles (>=1)
//  SCAN_GAP  64    idle cycles between end of one scan and the next scan request
// PORTS
//  clk         in   1           clock (RAM clock_b driven from same clk)
//  reset       in   1           synchronous, active-high reset
//  enable      in   1           1 = scheduler runs; 0 = park in IDLE after current op
//  mem_address out  AW          port B address
//  mem_data    out  DW          port B write data
//  mem_rden    out  1           port B read enable, 1-cycle pulse
//  mem_wren    out  1           port B write enable, 1-cycle pulse
//  mem_q       in   DW          port B read data, valid RD_LAT cycles after mem_rden
//  sts_req     in   N_STS       per-writer request, held until acked
//  sts_addr    in   N_STS*AW    per-writer address, flattened, writer i at [i*AW +: AW]
//  sts_data    in   N_STS*DW    per-writer data, flattened likewise
//  sts_ack     out  N_STS       1-cycle grant/complete pulse to writer
//  sts_err     out  1           1-cycle pulse: acked write dropped (address in config region)
//  cfg_word    out  N_CFG*DW    shadow config words, word i at [i*DW +: DW]
//  cfg_valid   out  1           set after first completed scan, cleared only by reset
//  cfg_update  out  1           1-cycle pulse in the cycle cfg_word takes new values
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; rr pointer=0; scan index=0; gap counter=0 (scan due at once); last_wr=0.
//  FSM states: IDLE, ARB, WR, RD, WAIT.
//  - IDLE: enable=1 -> ARB next cycle.
//  - ARB: enable=0 -> IDLE, discard partial staging, idx=0.
//    Else if scan due and (no sts_req or last_wr=1) -> RD.
//    Else if any sts_req -> WR, grantee = first requester at/after rr pointer. Else stay in ARB.
//  - WR (1 cycle): sts_ack[g]=1; rr pointer=g+1 mod N_STS; last_wr=1; -> ARB.
//    Address outside [CFG_BASE, CFG_BASE+N_CFG): mem_wren=1 with sts_addr/sts_data of g.
//    Address inside that range: mem_wren=0, sts_err=1.
//  - RD (1 cycle): mem_rden=1, mem_address=CFG_BASE+idx; last_wr=0; -> WAIT.
//  - WAIT (RD_LAT cycles): at the edge ending the last WAIT cycle, stage[idx]<=mem_q.
//    idx<N_CFG-1: idx++. idx=N_CFG-1: commit (below), idx=0, gap<=SCAN_GAP. Then -> ARB.
//    enable is ignored until WAIT completes.
//  - Commit: cfg_word<=stage[] all words together plus that last capture; cfg_update=1 in the next cycle; cfg_valid<=1.
//  - Gap counter: decrements each cycle while >0 and state!=IDLE. Scan due = (gap==0), and at a scan start (idx=0).
//  - Address arithmetic CFG_BASE+idx is AW bits wide, wrapping mod 2^AW.
//  - Outputs mem_* and sts_* are registered; mem_address/mem_data hold their last value when not enabled.
//  - A write to the config region by Avalon (port A) is seen at the next scan, not before.
//  - sts_req dropped before ack: no write occurs and the request is ignored.
//  - Reset asserted mid-operation: returns to reset values on that edge; an in-flight read result is discarded.
// TESTING
//  1 Reset, RAM[0..3]=1,2,3,4, enable=1 sampled cycle 0 -> RD at cycles 2,6,10,14;
//    cfg_update pulse cycle 17; cfg_word={4,3,2,1}; cfg_valid=1.
//  2 sts_req=2'b11 held, addrs 0x100/0x101, data A/B -> acks to writer 0 then writer 1 (separate WR cycles);
//    RAM[0x100]=A, RAM[0x101]=B.
//  3 Writer 0 requests continuously with scan due -> WR and RD alternate; scan completes within 2*4*N_CFG cycles.
//  4 Writer 1 addr=0x002 (config region) -> sts_ack[1]=1 with sts_err=1, mem_wren stays 0, RAM[2] unchanged.
//  5 enable dropped during WAIT of word 2 -> capture finishes, then IDLE; cfg_word unchanged, no cfg_update;
//    re-enable -> scan restarts at idx 0.
//  6 Port A writes RAM[1]=0xFEFE after a scan -> next scan (>=SCAN_GAP cycles later) gives cfg_word[1]=0xFEFE.

Source files
------------

// File: rtl/reg_ram_portb_scheduler.sv
// Port-B owner for the register RAM: periodically scans the config block into shadow
// outputs and arbitrates round-robin between status writers, one RAM operation at a time.
module reg_ram_portb_scheduler #(
    parameter int unsigned AW       = 11,
    parameter int unsigned DW       = 32,
    parameter int unsigned N_CFG    = 4,
    parameter int unsigned CFG_BASE = 0,
    parameter int unsigned N_STS    = 2,
    parameter int unsigned RD_LAT   = 2,
    parameter int unsigned SCAN_GAP = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic [AW-1:0]         mem_address,
    output logic [DW-1:0]         mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DW-1:0]         mem_q,
    input  logic [N_STS-1:0]      sts_req,
    input  logic [N_STS*AW-1:0]   sts_addr,
    input  logic [N_STS*DW-1:0]   sts_data,
    output logic [N_STS-1:0]      sts_ack,
    output logic                  sts_err,
    output logic [N_CFG*DW-1:0]   cfg_word,
    output logic                  cfg_valid,
    output logic                  cfg_update
);

    localparam int unsigned IW = (N_CFG > 1)    ? $clog2(N_CFG)        : 1;
    localparam int unsigned RW = (N_STS > 1)    ? $clog2(N_STS)        : 1;
    localparam int unsigned GW = (SCAN_GAP > 0) ? $clog2(SCAN_GAP + 1) : 1;
    localparam int unsigned LW = (RD_LAT > 1)   ? $clog2(RD_LAT)       : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARB  = 3'd1;
    localparam logic [2:0] S_WR   = 3'd2;
    localparam logic [2:0] S_RD   = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [RW-1:0]       rr_q, rr_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [LW-1:0]       wcnt_q, wcnt_d;
    logic                last_wr_q, last_wr_d;
    logic [N_CFG*DW-1:0] stage_q, stage_d;
    logic [N_CFG*DW-1:0] cfg_word_q, cfg_word_d;
    logic                cfg_valid_q, cfg_valid_d;
    logic                cfg_update_q, cfg_update_d;
    logic [AW-1:0]       mem_address_q, mem_address_d;
    logic [DW-1:0]       mem_data_q, mem_data_d;
    logic                mem_rden_q, mem_rden_d;
    logic                mem_wren_q, mem_wren_d;
    logic [N_STS-1:0]    sts_ack_q, sts_ack_d;
    logic                sts_err_q, sts_err_d;

    logic                gnt_any;
    logic [RW-1:0]       gnt_idx;
    logic [RW-1:0]       cand;
    logic [AW-1:0]       gnt_addr;
    logic [AW-1:0]       gnt_off;
    logic [DW-1:0]       gnt_data;
    logic                gnt_in_cfg;
    logic [N_CFG*DW-1:0] stage_cap;

    // First requester at or after the round-robin pointer.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < N_STS; k++) begin
            cand = RW'((32'(rr_q) + k) % N_STS);
            if (!gnt_any && sts_req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign gnt_addr   = sts_addr[32'(gnt_idx)*AW +: AW];
    assign gnt_data   = sts_data[32'(gnt_idx)*DW +: DW];
    assign gnt_off    = gnt_addr - AW'(CFG_BASE);
    assign gnt_in_cfg = (32'(gnt_off) < N_CFG);

    // Staging with the word arriving this cycle merged in; the commit uses it directly.
    always_comb begin
        stage_cap = stage_q;
        stage_cap[32'(idx_q)*DW +: DW] = mem_q;
    end

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        idx_d         = idx_q;
        gap_d         = gap_q;
        wcnt_d        = wcnt_q;
        last_wr_d     = last_wr_q;
        stage_d       = stage_q;
        cfg_word_d    = cfg_word_q;
        cfg_valid_d   = cfg_valid_q;
        cfg_update_d  = 1'b0;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_rden_d    = 1'b0;
        mem_wren_d    = 1'b0;
        sts_ack_d     = '0;
        sts_err_d     = 1'b0;

        if (state_q != S_IDLE && gap_q != '0) gap_d = gap_q - 1'b1;

        case (state_q)
            S_IDLE: if (enable) state_d = S_ARB;
            S_ARB: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (gap_q == '0 && (!gnt_any || last_wr_q)) begin
                    state_d       = S_RD;
                    mem_rden_d    = 1'b1;
                    mem_address_d = AW'(CFG_BASE) + AW'(idx_q);
                    last_wr_d     = 1'b0;
                    wcnt_d        = LW'(RD_LAT - 1);
                end else if (gnt_any) begin
                    state_d            = S_WR;
                    sts_ack_d[gnt_idx] = 1'b1;
                    rr_d               = (gnt_idx == RW'(N_STS - 1)) ? '0 : gnt_idx + 1'b1;
                    last_wr_d          = 1'b1;
                    if (gnt_in_cfg) begin
                        sts_err_d = 1'b1;
                    end else begin
                        mem_wren_d    = 1'b1;
                        mem_address_d = gnt_addr;
                        mem_data_d    = gnt_data;
                    end
                end
            end
            S_WR: state_d = S_ARB;
            S_RD: state_d = S_WAIT;
            S_WAIT: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - 1'b1;
                end else begin
                    state_d = S_ARB;
                    stage_d = stage_cap;
                    if (idx_q == IW'(N_CFG - 1)) begin
                        cfg_word_d   = stage_cap;
                        cfg_update_d = 1'b1;
                        cfg_valid_d  = 1'b1;
                        idx_d        = '0;
                        gap_d        = GW'(SCAN_GAP);
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rr_q          <= '0;
            idx_q         <= '0;
            gap_q         <= '0;
            wcnt_q        <= '0;
            last_wr_q     <= 1'b0;
            stage_q       <= '0;
            cfg_word_q    <= '0;
            cfg_valid_q   <= 1'b0;
            cfg_update_q  <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_rden_q    <= 1'b0;
            mem_wren_q    <= 1'b0;
            sts_ack_q     <= '0;
            sts_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            idx_q         <= idx_d;
            gap_q         <= gap_d;
            wcnt_q        <= wcnt_d;
            last_wr_q     <= last_wr_d;
            stage_q       <= stage_d;
            cfg_word_q    <= cfg_word_d;
            cfg_valid_q   <= cfg_valid_d;
            cfg_update_q  <= cfg_update_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_rden_q    <= mem_rden_d;
            mem_wren_q    <= mem_wren_d;
            sts_ack_q     <= sts_ack_d;
            sts_err_q     <= sts_err_d;
        end
    end

    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_rden    = mem_rden_q;
    assign mem_wren    = mem_wren_q;
    assign sts_ack     = sts_ack_q;
    assign sts_err     = sts_err_q;
    assign cfg_word    = cfg_word_q;
    assign cfg_valid   = cfg_valid_q;
    assign cfg_update  = cfg_update_q;

endmodule

// File: tb/tb_reg_ram_portb_scheduler.sv
// Bench for reg_ram_portb_scheduler: directed scenarios plus random status traffic,
// checked against a transaction-level model of grants, scans and RAM contents.
module tb_reg_ram_portb_scheduler;

    localparam int AW  = 11;
    localparam int DW  = 32;
    localparam int NC  = 4;
    localparam int NS  = 2;
    localparam int LAT = 2;
    localparam int GAP = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [AW-1:0]     mem_address;
    logic [DW-1:0]     mem_data;
    logic              mem_rden;
    logic              mem_wren;
    logic [DW-1:0]     mem_q;
    logic [NS-1:0]     sts_req;
    logic [NS*AW-1:0]  sts_addr;
    logic [NS*DW-1:0]  sts_data;
    logic [NS-1:0]     sts_ack;
    logic              sts_err;
    logic [NC*DW-1:0]  cfg_word;
    logic              cfg_valid;
    logic              cfg_update;

    // RAM model: port A driven by the bench, port B by the DUT, read latency LAT.
    logic              pa_we;
    logic [AW-1:0]     pa_addr;
    logic [DW-1:0]     pa_data;
    logic [DW-1:0]     ram [2**AW];
    logic [DW-1:0]     rd_p1;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pa_we) ram[pa_addr] <= pa_data;
        if (mem_wren) ram[mem_address] <= mem_data;
        rd_p1 <= mem_rden ? ram[mem_address] : '0;
        mem_q <= rd_p1;
    end

    reg_ram_portb_scheduler #(
        .AW(AW), .DW(DW), .N_CFG(NC), .CFG_BASE(0), .N_STS(NS), .RD_LAT(LAT), .SCAN_GAP(GAP)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .mem_address(mem_address), .mem_data(mem_data), .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_q(mem_q), .sts_req(sts_req), .sts_addr(sts_addr), .sts_data(sts_data),
        .sts_ack(sts_ack), .sts_err(sts_err), .cfg_word(cfg_word), .cfg_valid(cfg_valid),
        .cfg_update(cfg_update)
    );

    int n_chk = 0;
    int n_pass = 0;
    int n = 0;
    bit mon_on = 0;
    int mode = 0;          // 0 manual, 1 random, 2 writer0 continuous, 3 drop on ack
    int rr_m, rd_idx_m, last_upd, upd_count;
    bit seen_upd, have_upd;
    logic [NC*DW-1:0] cfg_prev;
    logic [DW-1:0] exp_ram [2**AW];
    bit wr_known [2**AW];
    int rds[$];
    int order[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    function automatic int rr_first(input logic [NS-1:0] req, input int rr);
        for (int k = 0; k < NS; k++)
            if (req[(rr + k) % NS]) return (rr + k) % NS;
        return -1;
    endfunction

    task automatic monitor();
        logic [AW-1:0] a;
        bit incfg;
        int g;
        if (reset) begin
            rr_m = 0; rd_idx_m = 0; cfg_prev = '0; seen_upd = 0; have_upd = 0;
            return;
        end
        chk("one_op", mem_rden & mem_wren, 0);
        chk("ack_onehot", $countones(sts_ack) <= 1, 1);
        if (|sts_ack) begin
            g = 0;
            for (int i = 0; i < NS; i++) if (sts_ack[i]) g = i;
            chk("rr_grant", g, rr_first(sts_req, rr_m));
            a = sts_addr[g*AW +: AW];
            incfg = (a < NC);
            chk("ack_err", sts_err, incfg);
            chk("ack_wren", mem_wren, !incfg);
            if (!incfg) begin
                chk("wr_addr", mem_address, a);
                chk("wr_data", mem_data, sts_data[g*DW +: DW]);
                exp_ram[a] = sts_data[g*DW +: DW];
                wr_known[a] = 1;
            end
            rr_m = (g + 1) % NS;
        end else begin
            chk("idle_wren", mem_wren, 0);
            chk("idle_err", sts_err, 0);
        end
        if (mem_rden) begin
            chk("rd_addr", mem_address, rd_idx_m);
            if (rd_idx_m == 0 && have_upd) chk("scan_gap", (n - last_upd) >= GAP, 1);
            rd_idx_m++;
        end
        if (cfg_update) begin
            chk("scan_len", rd_idx_m, NC);
            chk("cfg_word", cfg_word, {exp_ram[3], exp_ram[2], exp_ram[1], exp_ram[0]});
            cfg_prev = cfg_word; rd_idx_m = 0; seen_upd = 1; have_upd = 1;
            last_upd = n; upd_count++;
        end else begin
            chk("cfg_hold", cfg_word, cfg_prev);
        end
        chk("cfg_valid", cfg_valid, seen_upd);
    endtask

    task automatic drive_writers();
        for (int i = 0; i < NS; i++) begin
            if (mode == 0) continue;
            if (sts_ack[i]) begin
                sts_req[i] = 1'b0;
                if (mode == 2 && i == 0) begin
                    sts_addr[0 +: AW] = AW'(12'h180 + $urandom_range(0, 15));
                    sts_data[0 +: DW] = $urandom;
                    sts_req[0] = 1'b1;
                end
            end else if (mode == 1) begin
                if (!sts_req[i] && $urandom_range(0, 5) == 0) begin
                    if ($urandom_range(0, 7) == 0) sts_addr[i*AW +: AW] = AW'($urandom_range(0, 5));
                    else sts_addr[i*AW +: AW] = AW'(12'h100 + $urandom_range(0, 63));
                    sts_data[i*DW +: DW] = $urandom;
                    sts_req[i] = 1'b1;
                end else if (sts_req[i] && $urandom_range(0, 60) == 0) begin
                    sts_req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
        if (mon_on) monitor();
        #1;
        pa_we = 1'b0;
        drive_writers();
    endtask

    task automatic pa_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pa_we = 1'b1; pa_addr = a; pa_data = d;
        exp_ram[a] = d;
        step();
    endtask

    // kind: 0 rden, 1 cfg_update, 2 any ack
    task automatic wait_for(input int kind, input int budget, input string tag);
        bit hit;
        hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            step();
            hit = (kind == 0) ? mem_rden : (kind == 1) ? cfg_update : (|sts_ack);
        end
        chk(tag, hit, 1);
    endtask

    task automatic check_reset_outs(input string tag);
        chk(tag, {mem_address, mem_data, mem_rden, mem_wren, sts_ack, sts_err, cfg_valid, cfg_update}, 0);
        chk({tag, "_cfg"}, cfg_word, 0);
    endtask

    initial begin
        int nb, c, upd_c, wr, t0;
        bit hit;
        reset = 1'b1; enable = 1'b0; sts_req = '0; sts_addr = '0; sts_data = '0;
        pa_we = 1'b0; pa_addr = '0; pa_data = '0;
        upd_count = 0;
        step(); step();
        mon_on = 1;
        for (int k = 0; k < NC; k++) pa_write(AW'(k), DW'(k + 1));
        check_reset_outs("reset");

        // 1: first scan timing and contents
        reset = 1'b0; enable = 1'b1; nb = n; upd_c = -1;
        for (int i = 0; i < 18; i++) begin
            step();
            c = n - nb;
            if (mem_rden) rds.push_back(c);
            if (cfg_update) upd_c = c;
        end
        chk("t1_rd_count", rds.size(), 4);
        for (int i = 0; i < 4 && i < rds.size(); i++) chk("t1_rd_cycle", rds[i], 2 + 4*i);
        chk("t1_upd_cycle", upd_c, 17);
        chk("t1_cfg", cfg_word, {32'd4, 32'd3, 32'd2, 32'd1});
        chk("t1_valid", cfg_valid, 1);

        // 2: two writers held, served in round-robin order
        mode = 3;
        sts_addr = {11'h101, 11'h100};
        sts_data = {32'hBBBB_0002, 32'hAAAA_0001};
        sts_req = 2'b11;
        for (int i = 0; i < 20 && order.size() < 2; i++) begin
            step();
            for (int w = 0; w < NS; w++) if (sts_ack[w]) order.push_back(w);
        end
        chk("t2_acks", order.size(), 2);
        if (order.size() == 2) begin
            chk("t2_first", order[0], 0);
            chk("t2_second", order[1], 1);
        end
        step(); step();
        chk("t2_ram100", ram[11'h100], 32'hAAAA_0001);
        chk("t2_ram101", ram[11'h101], 32'hBBBB_0002);

        // 4: write into config region is acked with error and dropped
        sts_addr[AW +: AW] = 11'h002;
        sts_data[DW +: DW] = 32'hDEAD_BEEF;
        sts_req = 2'b10;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (|sts_ack) begin
                hit = 1;
                chk("t4_ack", sts_ack, 2'b10);
                chk("t4_err", sts_err, 1);
                chk("t4_wren", mem_wren, 0);
            end
        end
        chk("t4_seen", hit, 1);
        step(); step();
        chk("t4_ram2", ram[2], 32'd3);

        // reset in the middle of a read
        wait_for(0, 120, "mid_rd_seen");
        step();
        reset = 1'b1;
        step();
        check_reset_outs("mid_reset");

        // 5: enable dropped during the wait of word 2
        reset = 1'b0;
        hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            step();
            hit = mem_rden && (mem_address == 2);
        end
        chk("t5_rd2", hit, 1);
        step();
        enable = 1'b0;
        c = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (cfg_update) c++;
        end
        chk("t5_no_update", c, 0);
        chk("t5_valid", cfg_valid, 0);
        rd_idx_m = 0;
        enable = 1'b1;
        wait_for(0, 10, "t5_restart");
        chk("t5_restart_idx0", mem_address, 0);
        wait_for(1, 30, "t5_update");
        chk("t5_cfg", cfg_word, {32'd4, 32'd3, 32'd2, 32'd1});

        // 3: continuous writer with a scan due alternates WR and RD
        reset = 1'b1;
        step();
        reset = 1'b0; mode = 2;
        sts_addr[0 +: AW] = 11'h180; sts_data[0 +: DW] = 32'h1234_5678; sts_req = 2'b01;
        wr = 0; hit = 0;
        for (int i = 0; i < 2*4*NC && !hit; i++) begin
            step();
            if (mem_wren) wr++;
            if (cfg_update) hit = 1;
        end
        chk("t3_scan_in_time", hit, 1);
        chk("t3_wr_count", wr, NC);
        mode = 3;
        step(); step(); step();

        // 6: port-A write to a config word shows up at the next scan
        t0 = last_upd;
        pa_write(11'h001, 32'h0000_FEFE);
        wait_for(1, 200, "t6_update");
        chk("t6_word1", cfg_word[DW +: DW], 32'h0000_FEFE);
        chk("t6_gap", (n - t0) >= GAP, 1);

        // random traffic
        c = upd_count;
        mode = 1;
        for (int i = 0; i < 3000; i++) step();
        mode = 3;
        for (int i = 0; i < 100 && sts_req != '0; i++) step();
        chk("drain", sts_req, 0);
        step(); step();
        chk("rand_scans", (upd_count - c) >= 10, 1);
        for (int a = 0; a < 2**AW; a++)
            if (wr_known[a]) chk("ram_content", ram[a], exp_ram[a]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
